// File: rtl/step_pulse_gen.sv
// Push-button conditioning: 2-FF synchroniser, debouncer and hold-to-auto-repeat FSM.
// Emits single-cycle step pulses on a debounced press and, while held with repeat_en, at a fixed rate.
//
// state  | meaning
// IDLE   | button released, waiting for a debounced press
// HOLD   | press pulse issued, timing the hold delay before auto-repeat
// REPEAT | auto-repeating every REPEAT_CYCLES while the button stays held
module step_pulse_gen #(
    parameter int unsigned DB_CYCLES     = 8,
    parameter int unsigned HOLD_CYCLES   = 32,
    parameter int unsigned REPEAT_CYCLES = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    input  logic repeat_en,
    output logic pressed,
    output logic step
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    if (DB_CYCLES == 0 || DB_CYCLES > CNT_MAX) begin : g_bad_db
        $error("step_pulse_gen: DB_CYCLES outside 1..2^CNT_W-1");
    end
    if (HOLD_CYCLES == 0 || HOLD_CYCLES > CNT_MAX) begin : g_bad_hold
        $error("step_pulse_gen: HOLD_CYCLES outside 1..2^CNT_W-1");
    end
    if (REPEAT_CYCLES == 0 || REPEAT_CYCLES > CNT_MAX) begin : g_bad_rep
        $error("step_pulse_gen: REPEAT_CYCLES outside 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic             s1_q;
    logic             btn_s_q;
    logic             pressed_q, pressed_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             step_q, step_d;
    state_t           state_q, state_d;

    // Any sample back at the debounced level restarts the count.
    always_comb begin
        pressed_d = pressed_q;
        db_cnt_d  = '0;
        if (btn_s_q != pressed_q) begin
            if (db_cnt_q == DB_LAST) begin
                pressed_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + ONE;
            end
        end
    end

    // Release is judged on the next debounced level so it pre-empts a coincident expiry.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = 1'b0;
        if (!pressed_d) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pressed_q) begin
                        step_d  = 1'b1;
                        state_d = HOLD;
                        timer_d = '0;
                    end
                end
                HOLD: begin
                    if (!repeat_en) begin
                        timer_d = '0;
                    end else if (timer_q == HOLD_LAST) begin
                        step_d  = 1'b1;
                        timer_d = '0;
                        state_d = REPEAT;
                    end else begin
                        timer_d = timer_q + ONE;
                    end
                end
                REPEAT: begin
                    if (!repeat_en) begin
                        timer_d = '0;
                        state_d = HOLD;
                    end else if (timer_q == REP_LAST) begin
                        step_d  = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= 1'b0;
            btn_s_q   <= 1'b0;
            pressed_q <= 1'b0;
            db_cnt_q  <= '0;
            timer_q   <= '0;
            step_q    <= 1'b0;
            state_q   <= IDLE;
        end else begin
            s1_q      <= btn_in;
            btn_s_q   <= s1_q;
            pressed_q <= pressed_d;
            db_cnt_q  <= db_cnt_d;
            timer_q   <= timer_d;
            step_q    <= step_d;
            state_q   <= state_d;
        end
    end

    assign pressed = pressed_q;
    assign step    = step_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: per-cycle comparison against a window-rule reference model
// plus scenario checks of pulse timing, release, reset and counter integration.
module tb_step_pulse_gen;

    localparam int DB   = 8;
    localparam int HOLD = 32;
    localparam int REP  = 8;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic btn_in    = 1'b0;
    logic repeat_en = 1'b0;
    logic pressed;
    logic step;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    step_pulse_gen #(
        .DB_CYCLES    (DB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .CNT_W        (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_in   (btn_in),
        .repeat_en(repeat_en),
        .pressed  (pressed),
        .step     (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the debounced level flips once the last DB synchronised samples
    // (raw samples two edges old) all differ from it; pulses follow enabled-hold counts.
    logic [DB:0] hist_q;
    logic        m_pressed;
    logic        m_step;
    logic        m_rep_phase;
    int          m_elapsed;
    logic        m_p_next;
    int          m_target;

    function automatic logic window_differs(input logic [DB:0] h, input logic lvl);
        for (int i = 1; i <= DB; i++) begin
            if (h[i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    assign m_p_next = window_differs(hist_q, m_pressed) ? ~m_pressed : m_pressed;
    assign m_target = m_rep_phase ? REP : HOLD;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q      <= '0;
            m_pressed   <= 1'b0;
            m_step      <= 1'b0;
            m_rep_phase <= 1'b0;
            m_elapsed   <= 0;
        end else begin
            m_step <= 1'b0;
            if (!m_p_next) begin
                m_elapsed   <= 0;
                m_rep_phase <= 1'b0;
            end else if (!m_pressed) begin
                m_step      <= 1'b1;
                m_elapsed   <= 0;
                m_rep_phase <= 1'b0;
            end else if (!repeat_en) begin
                m_elapsed   <= 0;
                m_rep_phase <= 1'b0;
            end else if (m_elapsed + 1 == m_target) begin
                m_step      <= 1'b1;
                m_elapsed   <= 0;
                m_rep_phase <= 1'b1;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
            m_pressed <= m_p_next;
            hist_q    <= {hist_q[DB-1:0], btn_in};
        end
    end

    task automatic test_reset();
        reset_n   = 1'b0;
        btn_in    = 1'b0;
        repeat_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pressed !== 1'b0) begin
            errors++;
            $display("FAIL reset_pressed: got %b want 0", pressed);
        end
        checks++;
        if (step !== 1'b0) begin
            errors++;
            $display("FAIL reset_step: got %b want 0", step);
        end
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (pressed !== m_pressed || step !== m_step) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
            end
        end
    endtask

    task automatic test_clean_press();
        int n_edge, first_step, nsteps, rel_edge, fall_edge;
        logic p_at_step;
        repeat_en  = 1'b0;
        btn_in     = 1'b1;
        n_edge     = cyc + 1;
        first_step = -1;
        nsteps     = 0;
        p_at_step  = 1'b0;
        repeat (50) begin
            @(negedge clk);
            checks++;
            if (pressed !== m_pressed || step !== m_step) begin
                errors++;
                $display("FAIL clean_model cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
            end
            if (step === 1'b1) begin
                nsteps++;
                if (first_step < 0) begin
                    first_step = cyc;
                    p_at_step  = pressed;
                end
            end
        end
        checks++;
        if (nsteps != 1) begin
            errors++;
            $display("FAIL clean_step_count: got %0d want 1", nsteps);
        end
        checks++;
        if (first_step != n_edge + DB + 1) begin
            errors++;
            $display("FAIL clean_step_edge: got %0d want %0d", first_step, n_edge + DB + 1);
        end
        checks++;
        if (p_at_step !== 1'b1) begin
            errors++;
            $display("FAIL clean_pressed_with_step: got %b want 1", p_at_step);
        end
        btn_in    = 1'b0;
        rel_edge  = cyc + 1;
        fall_edge = -1;
        nsteps    = 0;
        repeat (30) begin
            @(negedge clk);
            checks++;
            if (pressed !== m_pressed || step !== m_step) begin
                errors++;
                $display("FAIL release_model cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
            end
            if (step === 1'b1) nsteps++;
            if (pressed === 1'b0 && fall_edge < 0) fall_edge = cyc;
        end
        checks++;
        if (nsteps != 0) begin
            errors++;
            $display("FAIL release_steps: got %0d want 0", nsteps);
        end
        checks++;
        if (fall_edge != rel_edge + DB + 1) begin
            errors++;
            $display("FAIL release_edge: got %0d want %0d", fall_edge, rel_edge + DB + 1);
        end
    endtask

    task automatic test_bounce();
        int last_rise, first_step, nsteps, len;
        repeat_en  = 1'b0;
        first_step = -1;
        nsteps     = 0;
        last_rise  = 0;
        for (int k = 0; k < 24; k++) begin
            btn_in = ((k / 3) % 2 == 0);
            if (k % 6 == 0) last_rise = cyc + 1;
            @(negedge clk);
            checks++;
            if (pressed !== m_pressed || step !== m_step) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
            end
            if (step === 1'b1) nsteps++;
        end
        btn_in    = 1'b1;
        last_rise = cyc + 1;
        repeat (30) begin
            @(negedge clk);
            checks++;
            if (pressed !== m_pressed || step !== m_step) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
            end
            if (step === 1'b1) begin
                nsteps++;
                if (first_step < 0) first_step = cyc;
            end
        end
        checks++;
        if (nsteps != 1) begin
            errors++;
            $display("FAIL bounce_step_count: got %0d want 1", nsteps);
        end
        checks++;
        if (first_step != last_rise + DB + 1) begin
            errors++;
            $display("FAIL bounce_step_edge: got %0d want %0d", first_step, last_rise + DB + 1);
        end
        repeat (5) begin
            len    = $urandom_range(1, DB - 1);
            btn_in = 1'b0;
            repeat (len) @(negedge clk);
            btn_in = 1'b1;
            repeat ($urandom_range(DB, 2 * DB)) begin
                @(negedge clk);
                checks++;
                if (pressed !== 1'b1 || step !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_hold cyc=%0d len=%0d: got p=%b s=%b want p=1 s=0", cyc, len, pressed, step);
                end
            end
        end
        btn_in = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (pressed !== m_pressed || step !== m_step) begin
                errors++;
                $display("FAIL bounce_release cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int p, fall_edge;
        int offs[$];
        int exp_off[$];
        repeat_en = 1'b1;
        btn_in    = 1'b1;
        p         = cyc + 1 + DB + 1;
        fall_edge = -1;
        exp_off   = {0};
        for (int i = 0; i < 6; i++) exp_off.push_back(HOLD + i * REP);
        while (cyc < p + 100) begin
            @(negedge clk);
            checks++;
            if (pressed !== m_pressed || step !== m_step) begin
                errors++;
                $display("FAIL repeat_model cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
            end
            if (step === 1'b1) offs.push_back(cyc - p);
            if (cyc > p && pressed === 1'b0 && fall_edge < 0) fall_edge = cyc;
            if (cyc == p + 70) btn_in = 1'b0;
        end
        checks++;
        if (offs.size() != exp_off.size()) begin
            errors++;
            $display("FAIL repeat_count: got %0d want %0d", offs.size(), exp_off.size());
        end else begin
            foreach (exp_off[i]) begin
                checks++;
                if (offs[i] != exp_off[i]) begin
                    errors++;
                    $display("FAIL repeat_offset[%0d]: got %0d want %0d", i, offs[i], exp_off[i]);
                end
            end
        end
        checks++;
        if (fall_edge != p + 80) begin
            errors++;
            $display("FAIL repeat_release_edge: got %0d want %0d", fall_edge, p + 80);
        end
    endtask

    task automatic test_repeat_toggle();
        int p;
        int offs[$];
        int exp_off[$];
        repeat_en = 1'b1;
        btn_in    = 1'b1;
        p         = cyc + 1 + DB + 1;
        exp_off   = {0, HOLD, 50 + HOLD, 50 + HOLD + REP, 50 + HOLD + 2 * REP};
        while (cyc < p + 125) begin
            @(negedge clk);
            checks++;
            if (pressed !== m_pressed || step !== m_step) begin
                errors++;
                $display("FAIL toggle_model cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
            end
            if (step === 1'b1) offs.push_back(cyc - p);
            if (cyc == p + 36) repeat_en = 1'b0;
            if (cyc == p + 50) repeat_en = 1'b1;
            if (cyc == p + 95) btn_in = 1'b0;
        end
        checks++;
        if (offs.size() != exp_off.size()) begin
            errors++;
            $display("FAIL toggle_count: got %0d want %0d", offs.size(), exp_off.size());
        end else begin
            foreach (exp_off[i]) begin
                checks++;
                if (offs[i] != exp_off[i]) begin
                    errors++;
                    $display("FAIL toggle_offset[%0d]: got %0d want %0d", i, offs[i], exp_off[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int p, p2;
        int offs[$];
        int exp_off[$];
        repeat_en = 1'b1;
        btn_in    = 1'b1;
        p         = cyc + 1 + DB + 1;
        while (cyc < p + 45) begin
            @(negedge clk);
            checks++;
            if (pressed !== m_pressed || step !== m_step) begin
                errors++;
                $display("FAIL midrst_model cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
            end
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (pressed !== 1'b0 || step !== 1'b0) begin
            errors++;
            $display("FAIL midrst_immediate: got p=%b s=%b want p=0 s=0", pressed, step);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (pressed !== 1'b0 || step !== 1'b0) begin
                errors++;
                $display("FAIL midrst_held cyc=%0d: got p=%b s=%b want p=0 s=0", cyc, pressed, step);
            end
        end
        reset_n = 1'b1;
        p2      = cyc + 1 + DB + 1;
        exp_off = {0, HOLD, HOLD + REP, HOLD + 2 * REP};
        while (cyc < p2 + 50) begin
            @(negedge clk);
            checks++;
            if (pressed !== m_pressed || step !== m_step) begin
                errors++;
                $display("FAIL midrst_resume cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
            end
            if (step === 1'b1) offs.push_back(cyc - p2);
        end
        checks++;
        if (offs.size() != exp_off.size()) begin
            errors++;
            $display("FAIL midrst_count: got %0d want %0d", offs.size(), exp_off.size());
        end else begin
            foreach (exp_off[i]) begin
                checks++;
                if (offs[i] != exp_off[i]) begin
                    errors++;
                    $display("FAIL midrst_offset[%0d]: got %0d want %0d", i, offs[i], exp_off[i]);
                end
            end
        end
        btn_in = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_counter();
        logic [3:0] cnt4;
        int got;
        cnt4      = 4'd0;
        repeat_en = 1'b0;
        for (int k = 0; k < 17; k++) begin
            got = 0;
            for (int ph = 0; ph < 2; ph++) begin
                btn_in = (ph == 0);
                repeat (20) begin
                    @(negedge clk);
                    checks++;
                    if (pressed !== m_pressed || step !== m_step) begin
                        errors++;
                        $display("FAIL counter_model cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
                    end
                    if (step === 1'b1) begin
                        got++;
                        cnt4 = cnt4 + 4'd1;
                    end
                end
            end
            checks++;
            if (got != 1) begin
                errors++;
                $display("FAIL counter_press[%0d]: got %0d steps want 1", k, got);
            end
        end
        checks++;
        if (cnt4 !== 4'd1) begin
            errors++;
            $display("FAIL counter_final: got %0d want 1", cnt4);
        end
    endtask

    task automatic test_random();
        int rate;
        for (int seg = 0; seg < 10; seg++) begin
            rate = ($urandom_range(0, 1) == 1) ? 4 : 60;
            repeat (100) begin
                if ($urandom_range(0, rate - 1) == 0) btn_in = ~btn_in;
                if ($urandom_range(0, 49) == 0) repeat_en = ~repeat_en;
                @(negedge clk);
                checks++;
                if (pressed !== m_pressed || step !== m_step) begin
                    errors++;
                    $display("FAIL random_model cyc=%0d: got p=%b s=%b want p=%b s=%b", cyc, pressed, step, m_pressed, m_step);
                end
            end
        end
        btn_in = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_repeat_toggle();
        test_reset_mid();
        test_counter();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Upstream conditioning stage for the 4-bit binary counter: turns a raw push-button into clean, single-cycle `step` pulses that drive the counter's `enable` input.
- Contains a 2-FF synchroniser, a debouncer and a hold-to-auto-repeat FSM.
- One press gives exactly one count. Holding the button (when `repeat_en` is high) gives repeated counts at a fixed rate.

Parameters:
- DB_CYCLES, 8: consecutive cycles the synchronised input must differ from the debounced level before that level flips. Range 1..2^CNT_W-1.
- HOLD_CYCLES, 32: cycles the button must stay held after the press pulse before the first auto-repeat pulse. Range 1..2^CNT_W-1.
- REPEAT_CYCLES, 8: interval between auto-repeat pulses. Range 1..2^CNT_W-1.
- CNT_W, 16: width of the internal debounce counter and the hold/repeat timer.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset; clears all state including the synchroniser flops.
- btn_in  in  1  raw button, asynchronous to clk, bouncy, active-high.
- repeat_en  in  1  synchronous; 1 enables auto-repeat while the button is held.
- pressed  out  1  debounced button level (registered).
- step  out  1  single-cycle pulse (registered); connects to the counter's enable.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - sync flops, pressed, step, debounce counter, timer <= 0.
  - FSM <= IDLE.
  - Takes effect immediately, including mid-hold or mid-repeat. No pulse is emitted on reset exit.
- Synchroniser:
  - btn_in -> s1 -> btn_s, two flops.
  - btn_s is the only internal use of btn_in.
- Debouncer, per edge:
  - btn_s == pressed: counter <= 0.
  - btn_s != pressed and counter == DB_CYCLES-1: pressed <= btn_s, counter <= 0.
  - btn_s != pressed otherwise: counter++.
  - Any bounce back to the pressed level restarts the count. Counter never wraps.
- Latency: btn_in first sampled high at edge N (and stable after) -> pressed=1 and step=1 after edge N+DB_CYCLES+1. That is DB_CYCLES+2 edges including N. Release has the same latency and never produces a step.
- FSM states and transitions:
  - IDLE: timer=0. On the edge where pressed goes 0->1: step<=1, go to HOLD, timer<=0.
  - HOLD:
    - If repeat_en=1: timer++.
    - If repeat_en=1 and timer==HOLD_CYCLES-1: step<=1, timer<=0, go to REPEAT.
    - If repeat_en=0: timer<=0, stay in HOLD.
  - REPEAT:
    - If repeat_en=1: timer++.
    - If repeat_en=1 and timer==REPEAT_CYCLES-1: step<=1, timer<=0.
    - If repeat_en=0: timer<=0, go to HOLD (the hold delay restarts if re-enabled).
  - Any state: pressed==0 -> IDLE, timer<=0, step<=0. Release has priority over a coincident repeat expiry, so no pulse.
- step is 0 in every cycle not listed above, so it is never high for two consecutive cycles.
- Pulse timing from the press pulse at cycle P (repeat_en=1 throughout): pulses at P, P+HOLD_CYCLES, then every REPEAT_CYCLES.
- Parameter values outside their ranges are illegal. A simulation-time check reports an error.

Test Plan:
- Clean press, DB_CYCLES=8:
  - Stimulus: btn_in 0->1 held for 50 cycles, repeat_en=0.
  - Response: step high for exactly 1 cycle, 10 edges after first sampled high; pressed=1 in the same cycle; no further steps.
  - Release: pressed falls 10 edges after, step stays 0.
- Bounce rejection:
  - Stimulus: btn_in toggles every 3 cycles for 24 cycles, then stable high.
  - Response: exactly 1 step, 10 edges after the last rising toggle; glitches under 8 cycles while held leave pressed=1.
- Auto-repeat, HOLD=32, REPEAT=8, repeat_en=1:
  - Stimulus: hold for 80 cycles after press pulse P.
  - Response: steps at P, P+32, P+40, P+48, P+56, P+64, P+72, i.e. 7 pulses. Releasing with the timer at REPEAT_CYCLES-1 gives no pulse.
- repeat_en toggle:
  - Stimulus: drop repeat_en at P+36, re-raise at P+50.
  - Response: no steps from P+33 to P+81; next step at P+82.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 for 3 cycles in REPEAT with btn held.
  - Response: pressed, step, FSM state = 0/0/IDLE immediately. After reset release with btn still high: one new step 10 edges later, then repeat resumes per schedule.
- Integration with the 4-bit counter:
  - Stimulus: step wired to enable; 17 clean presses, repeat_en=0.
  - Response: count == 1 (wrapped past 15 -> 0), with exactly one increment per press.
